// File: rtl/sram_bank_ctrl_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// sram_bank_ctrl_if
// Request/response channel between a CPU-side requester and sram_bank_ctrl.
//
// Handshake semantics:
//   - A request transfers on a rising edge where req_valid && req_ready are
//     both high. The requester must hold every req_* field stable while
//     req_valid is high and req_ready is low. The controller samples all
//     request fields on the transfer edge only.
//   - rsp_valid is a single-cycle pulse per accepted request. There is no
//     rsp_ready: the requester must be able to take the response in any cycle.
//     rsp_err and rsp_rdata are meaningful only while rsp_valid is high.
//
// Signals:
//   req_valid   requester -> ctrl   request present
//   req_ready   ctrl -> requester   controller idle and able to accept
//   req_we      requester -> ctrl   1 = write, 0 = read
//   req_size    requester -> ctrl   00 byte, 01 half, 10/11 word
//   req_signed  requester -> ctrl   read extension: 1 sign, 0 zero
//   req_addr    requester -> ctrl   byte address
//   req_wdata   requester -> ctrl   right-aligned write data
//   rsp_valid   ctrl -> requester   completion pulse
//   rsp_err     ctrl -> requester   misaligned request, no SRAM access made
//   rsp_rdata   ctrl -> requester   extended read data (0 for writes/errors)
// ----------------------------------------------------------------------------
interface sram_bank_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    // Requester side (CPU memory stage / fetch arbiter).
    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_size,
        output req_signed,
        output req_addr,
        output req_wdata,
        input  rsp_valid,
        input  rsp_err,
        input  rsp_rdata
    );

    // Controller side.
    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_size,
        input  req_signed,
        input  req_addr,
        input  req_wdata,
        output rsp_valid,
        output rsp_err,
        output rsp_rdata
    );
endinterface

// File: rtl/sram_bank_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// sram_bank_ctrl
// Clocked controller for the two asynchronous SRAM banks (BaseRAM / ExtRAM).
// Each accepted request performs one access with a programmable strobe width,
// byte/half/word lane steering on writes, sign/zero extension on reads, and
// misalignment detection (misaligned requests complete with an error and never
// touch the SRAM pins).
//
// Ports:
//   clk, rst           system clock; synchronous active-high reset
//   bus (slave)        request/response channel, see sram_bank_ctrl_if
//   base_ram_*         BaseRAM pins: data (inout), addr, be_n, ce_n, oe_n, we_n
//   ext_ram_*          ExtRAM pins, same set as BaseRAM
//   dbg_state          current FSM state (IDLE=0, ACCESS=1, RECOVER=2, ERR=3)
//
// Timing, counting the accept edge as cycle 0:
//   cycles 1..WAIT_CYCLES   ACCESS: ce_n low, oe_n or we_n low
//   cycle  WAIT_CYCLES+1    RECOVER: oe_n/we_n high, everything else held
//   cycle  WAIT_CYCLES+2    IDLE with rsp_valid high (a new request may be
//                           accepted in this same cycle)
//   Misaligned: ERR during cycle 1 with rsp_valid = rsp_err = 1.
// ----------------------------------------------------------------------------
module sram_bank_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_bank_ctrl_if.slave    bus,

    inout  wire  [DATA_W-1:0]  base_ram_data,
    output logic [ADDR_W-1:0]  base_ram_addr,
    output logic [3:0]         base_ram_be_n,
    output logic               base_ram_ce_n,
    output logic               base_ram_oe_n,
    output logic               base_ram_we_n,

    inout  wire  [DATA_W-1:0]  ext_ram_data,
    output logic [ADDR_W-1:0]  ext_ram_addr,
    output logic [3:0]         ext_ram_be_n,
    output logic               ext_ram_ce_n,
    output logic               ext_ram_oe_n,
    output logic               ext_ram_we_n,

    output logic [1:0]         dbg_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;
    localparam logic [1:0] ST_ERR     = 2'd3;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic              bank_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_raw_q;
    logic              base_drv_q;
    logic              ext_drv_q;

    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    // ------------------------------------------------------------------
    // Request decode (combinational, only used on the accept edge)
    // ------------------------------------------------------------------
    logic [1:0]        req_lane;
    logic [ADDR_W-1:0] req_word;
    logic              req_bank;
    logic              req_misaligned;
    logic [3:0]        req_be_n;
    logic [DATA_W-1:0] req_wdata_steered;
    logic              accept;

    assign req_lane = bus.req_addr[1:0];
    assign req_word = bus.req_addr[ADDR_W+1:2];
    assign req_bank = bus.req_addr[ADDR_W+2];

    // Address bits above the bank select do not reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+3];

    // Half needs an even lane; word (size 10 or 11) needs lane 0.
    assign req_misaligned = ((bus.req_size == 2'b01) && req_lane[0]) ||
                            (bus.req_size[1] && (req_lane != 2'b00));

    always_comb begin
        req_be_n          = 4'b0000;
        req_wdata_steered = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                req_be_n          = ~(4'b0001 << req_lane);
                req_wdata_steered = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                req_be_n          = req_lane[1] ? 4'b0011 : 4'b1100;
                req_wdata_steered = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                req_be_n          = 4'b0000;
                req_wdata_steered = bus.req_wdata;
            end
        endcase
    end

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    // ------------------------------------------------------------------
    // Read extraction from the word captured on the last ACCESS edge
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] rd_ext;

    // Shift the addressed lane down to bit 0; half uses lane 0 or 2.
    assign rd_shifted = rd_raw_q >> {lane_q, 3'b000};

    always_comb begin
        rd_ext = rd_raw_q;
        case (size_q)
            2'b00:   rd_ext = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   rd_ext = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_ext = rd_raw_q;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and all registered pin outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            lane_q        <= 2'b00;
            bank_q        <= 1'b0;
            wdata_q       <= '0;
            rd_raw_q      <= '0;
            base_drv_q    <= 1'b0;
            ext_drv_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            base_ram_addr <= '0;
            base_ram_be_n <= 4'hF;
            base_ram_ce_n <= 1'b1;
            base_ram_oe_n <= 1'b1;
            base_ram_we_n <= 1'b1;
            ext_ram_addr  <= '0;
            ext_ram_be_n  <= 4'hF;
            ext_ram_ce_n  <= 1'b1;
            ext_ram_oe_n  <= 1'b1;
            ext_ram_we_n  <= 1'b1;
        end else begin
            // Response outputs are pulses; default them low every cycle.
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q     <= bus.req_we;
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        lane_q   <= req_lane;
                        bank_q   <= req_bank;
                        wdata_q  <= req_wdata_steered;
                        if (req_misaligned) begin
                            state_q     <= ST_ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_ACCESS;
                            cnt_q   <= '0;
                            if (req_bank) begin
                                ext_ram_addr <= req_word;
                                ext_ram_be_n <= req_be_n;
                                ext_ram_ce_n <= 1'b0;
                                ext_ram_oe_n <= bus.req_we;
                                ext_ram_we_n <= ~bus.req_we;
                                ext_drv_q    <= bus.req_we;
                            end else begin
                                base_ram_addr <= req_word;
                                base_ram_be_n <= req_be_n;
                                base_ram_ce_n <= 1'b0;
                                base_ram_oe_n <= bus.req_we;
                                base_ram_we_n <= ~bus.req_we;
                                base_drv_q    <= bus.req_we;
                            end
                        end
                    end
                end

                ST_ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        // Last strobe edge: sample read data while oe_n is
                        // still low, then release the strobes for RECOVER.
                        state_q       <= ST_RECOVER;
                        base_ram_oe_n <= 1'b1;
                        base_ram_we_n <= 1'b1;
                        ext_ram_oe_n  <= 1'b1;
                        ext_ram_we_n  <= 1'b1;
                        if (!we_q) begin
                            rd_raw_q <= bank_q ? ext_ram_data : base_ram_data;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RECOVER: begin
                    // ce_n/addr/be_n/data were held through this cycle to
                    // give the SRAM hold time after the strobe rose.
                    state_q       <= ST_IDLE;
                    base_ram_ce_n <= 1'b1;
                    base_ram_be_n <= 4'hF;
                    ext_ram_ce_n  <= 1'b1;
                    ext_ram_be_n  <= 4'hF;
                    base_drv_q    <= 1'b0;
                    ext_drv_q     <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    rsp_rdata_q   <= we_q ? '0 : rd_ext;
                end

                ST_ERR: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign base_ram_data = base_drv_q ? wdata_q : {DATA_W{1'bz}};
    assign ext_ram_data  = ext_drv_q  ? wdata_q : {DATA_W{1'bz}};

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_sram_bank_ctrl
// Self-checking bench for sram_bank_ctrl: reset checks, a vector table of
// directed requests, hand-written pin-timing sequences, a reset in the middle
// of a write, and randomized requests checked against a byte-addressed model.
// ----------------------------------------------------------------------------
module tb_sram_bank_ctrl;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int WAIT   = 2;
    localparam int LAT_OK = WAIT + 2;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_bank_ctrl_if #(.DATA_W(DATA_W)) bus ();

    wire  [DATA_W-1:0] base_ram_data;
    logic [ADDR_W-1:0] base_ram_addr;
    logic [3:0]        base_ram_be_n;
    logic              base_ram_ce_n;
    logic              base_ram_oe_n;
    logic              base_ram_we_n;
    wire  [DATA_W-1:0] ext_ram_data;
    logic [ADDR_W-1:0] ext_ram_addr;
    logic [3:0]        ext_ram_be_n;
    logic              ext_ram_ce_n;
    logic              ext_ram_oe_n;
    logic              ext_ram_we_n;
    logic [1:0]        dbg_state;

    sram_bank_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
        .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
        .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
        .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
        .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
        .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
        .dbg_state(dbg_state)
    );

    // ------------------------------------------------------------------
    // Asynchronous SRAM pin models (small: word address bits [7:0] only)
    // ------------------------------------------------------------------
    logic [31:0] base_mem [0:255] = '{default: 32'd0};
    logic [31:0] ext_mem  [0:255] = '{default: 32'd0};

    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n && base_ram_we_n)
                           ? base_mem[base_ram_addr[7:0]] : 32'bz;
    assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n && ext_ram_we_n)
                           ? ext_mem[ext_ram_addr[7:0]] : 32'bz;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[i])
                base_mem[base_ram_addr[7:0]][8*i +: 8] <= base_ram_data[8*i +: 8];
            if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[i])
                ext_mem[ext_ram_addr[7:0]][8*i +: 8] <= ext_ram_data[8*i +: 8];
        end
    end

    // Bus monitor: count response pulses and cycles with both banks enabled.
    int rsp_cnt   = 0;
    int both_on   = 0;
    int ext_on    = 0;
    always @(negedge clk) begin
        if (bus.rsp_valid) rsp_cnt++;
        if (!base_ram_ce_n && !ext_ram_ce_n) both_on++;
        if (!ext_ram_ce_n) ext_on++;
    end

    // ------------------------------------------------------------------
    // Scoreboard and reporting
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];   // {err, rdata}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte-addressed memory keyed by {bank, word, lane}
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [int];

    function automatic int ref_nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    task automatic ref_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rdata);
        int n;
        int base;
        logic [31:0] v;
        n     = ref_nbytes(size);
        base  = int'(addr[22:0]);
        err   = (base % n) != 0;
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++)
                    if (ref_mem.exists(base + i)) v[8*i +: 8] = ref_mem[base + i];
                if (sgn && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1) | ((n == 4) ? 32'd0 : 32'd0);
                rdata = v;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle pin snapshots of the most recent request
    // ------------------------------------------------------------------
    typedef struct {
        logic        b_ce, b_oe, b_we;
        logic [3:0]  b_be;
        logic [19:0] b_addr;
        logic [31:0] b_data;
        logic        e_ce, e_oe, e_we;
        logic [3:0]  e_be;
        logic [19:0] e_addr;
        logic [31:0] e_data;
        logic        rdy;
    } snap_t;
    snap_t snap [0:15];

    task automatic take_snap(input int n);
        snap[n].b_ce = base_ram_ce_n; snap[n].b_oe = base_ram_oe_n; snap[n].b_we = base_ram_we_n;
        snap[n].b_be = base_ram_be_n; snap[n].b_addr = base_ram_addr; snap[n].b_data = base_ram_data;
        snap[n].e_ce = ext_ram_ce_n;  snap[n].e_oe = ext_ram_oe_n;  snap[n].e_we = ext_ram_we_n;
        snap[n].e_be = ext_ram_be_n;  snap[n].e_addr = ext_ram_addr; snap[n].e_data = ext_ram_data;
        snap[n].rdy  = bus.req_ready;
    endtask

    // ------------------------------------------------------------------
    // Driver: issue one request and wait (bounded) for its response
    // ------------------------------------------------------------------
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic err, output logic [31:0] rdata, output int lat);
        int t;
        err = 1'b0; rdata = 32'd0; lat = -1; t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_wait", 32'(t < 50), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Scramble fields after acceptance; the controller must ignore them.
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        for (int n = 1; n < 16; n++) begin
            @(negedge clk);
            take_snap(n);
            if (bus.rsp_valid) begin
                lat   = n;
                err   = bus.rsp_err;
                rdata = bus.rsp_rdata;
                break;
            end
        end
        chk("rsp_seen", 32'(lat > 0), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [0:15];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic        e;
        logic [31:0] d;
        int          lat;
        logic        r_err;
        logic [31:0] r_data;
        logic [32:0] exp_v;
        int          rsp_before;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0040_0003, 32'h1234_5680, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0040_0003, 32'h0,         1'b0, 32'hFFFF_FF80};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0040_0003, 32'h0,         1'b0, 32'h0000_0080};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h8001_1234, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,         1'b0, 32'hFFFF_8001};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_1234};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0000_0000};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 32'hFF00_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         1'b0, 32'h0000_00BE};
        vecs[13] = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         1'b0, 32'hFFFF_FFBE};
        vecs[14] = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_DEAD};
        vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h0040_0000, 32'h0,         1'b0, 32'h8000_0000};

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_base_ce_n", 32'(base_ram_ce_n), 32'd1);
        chk("rst_base_oe_we", {30'd0, base_ram_oe_n, base_ram_we_n}, 32'd3);
        chk("rst_ext_strobes", {29'd0, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'd7);
        chk("rst_be_n", {24'd0, base_ram_be_n, ext_ram_be_n}, 32'h0000_00FF);
        chk("rst_addr", {12'd0, base_ram_addr} | {12'd0, ext_ram_addr}, 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, e, d, lat);
            ref_access(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, r_err, r_data);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_lat", i), 32'(lat), vecs[i].exp_err ? 32'd1 : 32'(LAT_OK));
            if (!vecs[i].exp_err)
                chk($sformatf("vec%0d_ready_at_rsp", i), 32'(snap[lat].rdy), 32'd1);
        end
        chk("never_both_banks", 32'(both_on), 32'd0);

        // ---------------- word write pin timing (base bank) ----------------
        ext_on = 0;
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, e, d, lat);
        ref_access(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, r_err, r_data);
        chk("wr_addr", 32'(snap[1].b_addr), 32'd4);
        chk("wr_we_n_c1_c2", {30'd0, snap[1].b_we, snap[2].b_we}, 32'd0);
        chk("wr_we_n_c3", 32'(snap[3].b_we), 32'd1);
        chk("wr_ce_n_hold_c3", {30'd0, snap[1].b_ce, snap[3].b_ce}, 32'd0);
        chk("wr_oe_n", {30'd0, snap[1].b_oe, snap[2].b_oe}, 32'd3);
        chk("wr_be_n", {24'd0, snap[1].b_be, snap[3].b_be}, 32'd0);
        chk("wr_data_c1", snap[1].b_data, 32'hDEAD_BEEF);
        chk("wr_data_hold_c3", snap[3].b_data, 32'hDEAD_BEEF);
        chk("wr_ce_n_rsp", 32'(snap[4].b_ce), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, e, d, lat);
        chk("rd_oe_n_c1", {30'd0, snap[1].b_oe, snap[2].b_oe}, 32'd0);
        chk("rd_oe_n_c3", 32'(snap[3].b_oe), 32'd1);
        chk("rd_we_n", 32'(snap[1].b_we), 32'd1);
        chk("rd_data", d, 32'hDEAD_BEEF);
        chk("rd_lat", 32'(lat), 32'(LAT_OK));
        chk("ext_untouched", 32'(ext_on), 32'd0);

        // ---------------- byte write pins (ext bank) ----------------
        do_req(1'b1, 2'b00, 1'b0, 32'h0040_0003, 32'h0000_0080, e, d, lat);
        ref_access(1'b1, 2'b00, 1'b0, 32'h0040_0003, 32'h0000_0080, r_err, r_data);
        chk("bw_ext_ce_n", 32'(snap[1].e_ce), 32'd0);
        chk("bw_ext_addr", 32'(snap[1].e_addr), 32'd0);
        chk("bw_ext_be_n", 32'(snap[1].e_be), 32'h7);
        chk("bw_ext_data", snap[1].e_data, 32'h8080_8080);
        chk("bw_base_idle", {29'd0, snap[1].b_ce, snap[1].b_we, snap[1].b_oe}, 32'd7);

        // ---------------- misaligned request pins ----------------
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, e, d, lat);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_err", 32'(e), 32'd1);
        chk("mis_rdata", d, 32'd0);
        chk("mis_no_strobe", {28'd0, snap[1].b_ce, snap[1].b_oe, snap[1].e_ce, snap[1].e_oe}, 32'hF);
        @(negedge clk);
        chk("mis_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);

        // ---------------- reset in first ACCESS cycle of a write ----------------
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0000_00C0; bus.req_wdata = 32'hA5A5_5A5A;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_we_active", {30'd0, base_ram_ce_n, base_ram_we_n}, 32'd0);
        rsp_before = rsp_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_strobes", {29'd0, base_ram_ce_n, base_ram_we_n, base_ram_oe_n}, 32'd7);
        chk("mid_rst_be_n", 32'(base_ram_be_n), 32'hF);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        repeat (6) @(negedge clk);
        chk("mid_rst_no_rsp", 32'(rsp_cnt - rsp_before), 32'd0);

        // ---------------- randomized requests vs reference model ----------------
        for (int k = 0; k < 150; k++) begin
            logic        rwe;
            logic [1:0]  rsz;
            logic        rsg;
            logic [31:0] radr;
            logic [31:0] rwd;
            rwe  = 1'($urandom_range(0, 1));
            rsz  = 2'($urandom_range(0, 3));
            rsg  = 1'($urandom_range(0, 1));
            radr = {9'($urandom), 1'($urandom_range(0, 1)), 16'd0, 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3))};
            rwd  = $urandom;
            ref_access(rwe, rsz, rsg, radr, rwd, r_err, r_data);
            exp_q.push_back({r_err, r_data});
            do_req(rwe, rsz, rsg, radr, rwd, e, d, lat);
            exp_v = exp_q.pop_front();
            chk($sformatf("rnd%0d_err", k), 32'(e), 32'(exp_v[32]));
            chk($sformatf("rnd%0d_rdata", k), d, exp_v[31:0]);
            chk($sformatf("rnd%0d_lat", k), 32'(lat), exp_v[32] ? 32'd1 : 32'(LAT_OK));
        end
        chk("rnd_never_both_banks", 32'(both_on), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
